// File: rtl/pipe_adder_hs_pkg.sv
// Shared types and defaults for the pipelined handshake adder.
package pipe_adder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_TAG_W = 4;

    typedef enum logic {
        ADD_WRAP = 1'b0,
        ADD_SAT  = 1'b1
    } add_mode_e;

    // Payload layout at default widths; the top re-declares it at its own widths.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic                 ovf;
        logic [DEF_TAG_W-1:0] tag;
    } stage_payload_t;

endpackage

// File: rtl/pipe_adder_hs_if.sv
// Request/response handshake bundle for pipe_adder_hs.
interface pipe_adder_hs_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sat;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_sat, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sat, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_tag
    );
endinterface

// File: rtl/pipe_adder_hs_stage.sv
// One enabled pipeline slice: valid bit plus payload, async active-low reset.
module pipe_adder_stage #(
    parameter int DW = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_vld,
    input  logic [DW-1:0] i_data,
    output logic          o_vld,
    output logic [DW-1:0] o_data
);
    logic          r_vld;
    logic [DW-1:0] r_data;

    // Payload only loads with a valid item so the last stage holds its
    // previous result while bubbles pass through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (i_en) begin
            r_vld <= i_vld;
            if (i_vld)
                r_data <= i_data;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;
endmodule

// File: rtl/pipe_adder_hs.sv
// Pipelined unsigned adder with valid/ready on both sides, wrap/saturate mode.
// Optional statistics counters enabled by PIPE_ADDER_HS_STATS_EN.
module pipe_adder_hs
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = 2,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_adder_hs_if.slave   bus,
    output logic [CNT_W-1:0] stat_txn_cnt,
    output logic [CNT_W-1:0] stat_ovf_cnt
);
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } payload_t;

    localparam int PW = $bits(payload_t);

    logic                   w_adv;
    logic [WIDTH:0]         w_full;
    add_mode_e              w_mode;
    payload_t               w_in_pl;
    payload_t               w_out_pl;
    logic [STAGES:0]        w_vld;
    logic [STAGES:0][PW-1:0] w_data;
    logic                   w_fire;

    // Single global enable: the whole pipe moves unless the output is blocked.
    assign w_adv        = !w_vld[STAGES] || bus.out_ready;
    assign bus.in_ready = w_adv;

    assign w_full = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign w_mode = add_mode_e'(bus.in_sat);

    always_comb begin
        w_in_pl     = '0;
        w_in_pl.ovf = w_full[WIDTH];
        w_in_pl.sum = (w_full[WIDTH] && (w_mode == ADD_SAT)) ? {WIDTH{1'b1}}
                                                             : w_full[WIDTH-1:0];
        w_in_pl.tag = bus.in_tag;
    end

    assign w_vld[0]  = bus.in_valid;
    assign w_data[0] = w_in_pl;

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            pipe_adder_stage #(.DW(PW)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_en   (w_adv),
                .i_vld  (w_vld[g]),
                .i_data (w_data[g]),
                .o_vld  (w_vld[g+1]),
                .o_data (w_data[g+1])
            );
        end
    endgenerate

    assign w_out_pl      = payload_t'(w_data[STAGES]);
    assign bus.out_valid = w_vld[STAGES];
    assign bus.out_sum   = w_out_pl.sum;
    assign bus.out_ovf   = w_out_pl.ovf;
    assign bus.out_tag   = w_out_pl.tag;

    assign w_fire = w_vld[STAGES] && bus.out_ready;

`ifdef PIPE_ADDER_HS_STATS_EN
    logic [CNT_W-1:0] r_txn_cnt;
    logic [CNT_W-1:0] r_ovf_cnt;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn_cnt <= '0;
            r_ovf_cnt <= '0;
        end else if (w_fire) begin
            if (r_txn_cnt != {CNT_W{1'b1}})
                r_txn_cnt <= r_txn_cnt + 1'b1;
            if (w_out_pl.ovf && (r_ovf_cnt != {CNT_W{1'b1}}))
                r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign stat_txn_cnt = r_txn_cnt;
    assign stat_ovf_cnt = r_ovf_cnt;
`else
    logic w_unused;
    assign w_unused     = w_fire;
    assign stat_txn_cnt = '0;
    assign stat_ovf_cnt = '0;
`endif
endmodule
